de1_soc_sysid_checker: RTL and testbench
========================================

// Module: de1_soc_sysid_checker
// PURPOSE
//  Avalon-MM master sequencer that reads the system-ID slave at power-up or on
//  demand: word 0 (ID), then word 1 (timestamp). Compares both words against
//  the expected build values and reports sticky pass/fail and timeout status.
//  Sits between board-level health/LED logic and the QSYS sysid control slave.
// PARAMETERS
//  EXP_ID          32'd0           expected ID word (address 0)
//  EXP_TIMESTAMP   32'd1383718665  expected timestamp word (address 1)
//  READ_LATENCY    0               slave fixed read latency in cycles, 0..3
//  TIMEOUT_CYCLES  255             max waitrequest-stall cycles per read, >=1
//  RECHECK_PERIOD  50000000        auto re-check interval in cycles (periodic build only)
// PORTS
//  clock            in   1   system clock
//  reset_n          in   1   synchronous reset, active low
//  start            in   1   1-cycle request to run a check
//  busy             out  1   check sequence in progress
//  done             out  1   1-cycle pulse when a sequence ends, pass or fail
//  id_ok            out  1   sticky: ID word matched EXP_ID
//  ts_ok            out  1   sticky: timestamp word matched EXP_TIMESTAMP
//  pass             out  1   sticky: id_ok & ts_ok & !timeout_err
//  timeout_err      out  1   sticky: a read stalled TIMEOUT_CYCLES cycles
//  id_value         out  32  last captured ID word
//  ts_value         out  32  last captured timestamp word
//  avm_address      out  1   word address to slave
//  avm_read         out  1   read strobe
//  avm_waitrequest  in   1   slave stall; tie 0 for zero-wait slaves
//  avm_readdata     in   32  read data
// BEHAVIOUR
//  - Reset (reset_n=0 at a rising edge): all outputs 0, FSM->IDLE, counters 0.
//    Reset mid-sequence aborts immediately; no done pulse; avm_read=0 next cycle.
//  - FSM: IDLE -> RD_ID -> LAT_ID -> RD_TS -> LAT_TS -> FIN -> IDLE.
//  - IDLE: start=1 clears id_ok/ts_ok/pass/timeout_err, goes to RD_ID; busy=1
//    from the next cycle. start while busy is ignored (no queueing).
//  - RD_x: avm_read=1, avm_address=0 (ID) or 1 (TS), held stable while
//    avm_waitrequest=1. Accept = avm_read & !avm_waitrequest.
//  - READ_LATENCY=0: avm_readdata captured in the accept cycle; LAT_x skipped.
//    READ_LATENCY=L>0: avm_read drops after accept; LAT_x counts L cycles;
//    data captured on the L-th cycle after accept.
//  - Compare on capture: id_ok <= (data==EXP_ID); ts_ok <= (data==EXP_TIMESTAMP).
//  - Timeout: stall counter clears on entering RD_x, +1 each cycle with
//    avm_waitrequest=1. Reaching TIMEOUT_CYCLES: drop avm_read, timeout_err=1,
//    go to FIN; remaining reads are skipped.
//  - FIN: done=1 for one cycle, pass updated, busy=0 next cycle.
//  - Zero-wait, latency 0: start at cycle N -> done at N+4.
//  - Results and values hold until the next start or reset.
// CONFIGURATION
//  SYSID_CHECK_PERIODIC_EN defined: a free-running counter issues an internal
//    start every RECHECK_PERIOD cycles and one cycle after reset release.
//    Internal start is dropped if busy; external start still works.
//  Not defined: checks run only on external start; no period counter.
// TESTING
//  T1 zero-wait, L=0, slave returns 0/1383718665 -> done at start+4, pass=1.
//  T2 ID word returns 32'h1 -> id_ok=0, ts_ok=1, pass=0, id_value=1.
//  T3 waitrequest high 10 cycles on addr 1, L=2 -> address/read stable, pass=1.
//  T4 waitrequest stuck high, TIMEOUT_CYCLES=8 -> timeout_err=1, done after 8
//     stall cycles, pass=0, avm_read=0.
//  T5 reset_n low during LAT_TS -> all outputs 0 next edge; no done pulse.
//  T6 PERIODIC_EN, RECHECK_PERIOD=100 -> auto check after reset, then every 100.

Source files
------------

// File: rtl/de1_soc_sysid_checker.sv
// de1_soc_sysid_checker: Avalon-MM sequencer that reads and checks the sysid slave.
// Optional periodic re-check: define SYSID_CHECK_PERIODIC_EN.
module de1_soc_sysid_checker #(
  parameter logic [31:0] EXP_ID         = 32'd0,
  parameter logic [31:0] EXP_TIMESTAMP  = 32'd1383718665,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255
`ifdef SYSID_CHECK_PERIODIC_EN
  ,
  parameter int          RECHECK_PERIOD = 50000000
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  typedef enum logic [2:0] {
    IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN
  } state_e;

  localparam int SW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] LAT_N = 2'(READ_LATENCY);

  state_e state_q, state_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [1:0] lat_q, lat_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic id_ok_q, id_ok_d;
  logic ts_ok_q, ts_ok_d;
  logic pass_q, pass_d;
  logic tmo_q, tmo_d;
  logic [31:0] id_val_q, id_val_d;
  logic [31:0] ts_val_q, ts_val_d;
  logic go;
  logic cap_id;
  logic cap_ts;

`ifdef SYSID_CHECK_PERIODIC_EN
  localparam int PW = $clog2(RECHECK_PERIOD);
  localparam logic [PW-1:0] PER_MAX = PW'(RECHECK_PERIOD - 1);

  logic [PW-1:0] per_q, per_d;
  logic tick_q, tick_d;

  always_comb begin
    tick_d = (per_q == PER_MAX);
    per_d  = tick_d ? '0 : per_q + PW'(1);
  end

  // Counter parks at its terminal value in reset so the first tick
  // lands one cycle after release.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      per_q  <= PER_MAX;
      tick_q <= 1'b0;
    end else begin
      per_q  <= per_d;
      tick_q <= tick_d;
    end
  end

  assign go = start | tick_q;
`else
  assign go = start;
`endif

  always_comb begin
    state_d  = state_q;
    stall_d  = stall_q;
    lat_d    = lat_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    id_ok_d  = id_ok_q;
    ts_ok_d  = ts_ok_q;
    pass_d   = pass_q;
    tmo_d    = tmo_q;
    id_val_d = id_val_q;
    ts_val_d = ts_val_q;
    cap_id   = 1'b0;
    cap_ts   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = RD_ID;
          busy_d  = 1'b1;
          stall_d = '0;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          pass_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      RD_ID, RD_TS: begin
        if (!avm_waitrequest) begin
          if (READ_LATENCY == 0) begin
            cap_id  = (state_q == RD_ID);
            cap_ts  = (state_q == RD_TS);
            state_d = (state_q == RD_ID) ? RD_TS : FIN;
            stall_d = '0;
          end else begin
            lat_d   = 2'd1;
            state_d = (state_q == RD_ID) ? LAT_ID : LAT_TS;
          end
        end else if (stall_q == STALL_MAX) begin
          tmo_d   = 1'b1;
          state_d = FIN;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end
      LAT_ID, LAT_TS: begin
        if (lat_q == LAT_N) begin
          cap_id  = (state_q == LAT_ID);
          cap_ts  = (state_q == LAT_TS);
          state_d = (state_q == LAT_ID) ? RD_TS : FIN;
          stall_d = '0;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = id_ok_q & ts_ok_q & ~tmo_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cap_id) begin
      id_val_d = avm_readdata;
      id_ok_d  = (avm_readdata == EXP_ID);
    end
    if (cap_ts) begin
      ts_val_d = avm_readdata;
      ts_ok_d  = (avm_readdata == EXP_TIMESTAMP);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      stall_q  <= '0;
      lat_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      id_ok_q  <= 1'b0;
      ts_ok_q  <= 1'b0;
      pass_q   <= 1'b0;
      tmo_q    <= 1'b0;
      id_val_q <= '0;
      ts_val_q <= '0;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      lat_q    <= lat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      id_ok_q  <= id_ok_d;
      ts_ok_q  <= ts_ok_d;
      pass_q   <= pass_d;
      tmo_q    <= tmo_d;
      id_val_q <= id_val_d;
      ts_val_q <= ts_val_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign pass        = pass_q;
  assign timeout_err = tmo_q;
  assign id_value    = id_val_q;
  assign ts_value    = ts_val_q;
  assign avm_read    = (state_q == RD_ID) || (state_q == RD_TS);
  assign avm_address = (state_q == RD_TS);

endmodule

// File: tb/tb_de1_soc_sysid_checker.sv
// tb_de1_soc_sysid_checker: directed bench for the sysid checker.
// Instance a: latency 0, timeout 8. Instance b: latency 2, default timeout.
module tb_de1_soc_sysid_checker;

  localparam logic [31:0] EXP_TS = 32'd1383718665;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  logic start_a = 1'b0;
  logic busy_a, done_a, id_ok_a, ts_ok_a, pass_a, tmo_a;
  logic addr_a, rd_a, wr_a;
  logic [31:0] idv_a, tsv_a, rdata_a;
  logic [31:0] idw_a = 32'd0;
  logic [31:0] tsw_a = EXP_TS;
  logic stuck_a = 1'b0;

  assign wr_a = rd_a & stuck_a;
  assign rdata_a = addr_a ? tsw_a : idw_a;

  logic start_b = 1'b0;
  logic busy_b, done_b, id_ok_b, ts_ok_b, pass_b, tmo_b;
  logic addr_b, rd_b, wr_b;
  logic [31:0] idv_b, tsv_b, rdata_b;
  logic [31:0] idw_b = 32'd0;
  logic [31:0] tsw_b = EXP_TS;
  int stall_b = 0;
  int cnt_b = 0;
  int eff_b;
  logic lr_b = 1'b0;
  logic la_b = 1'b0;
  logic p1v = 1'b0;
  logic p1a = 1'b0;
  logic p2v = 1'b0;
  logic p2a = 1'b0;

  // slave b stalls the timestamp read and returns data two cycles after accept
  assign eff_b = (lr_b && la_b == addr_b) ? cnt_b : 0;
  assign wr_b = rd_b && addr_b && (eff_b < stall_b);
  assign rdata_b = p2v ? (p2a ? tsw_b : idw_b) : 32'hBAD0_BAD0;

  always @(posedge clock) begin
    lr_b  <= rd_b;
    la_b  <= addr_b;
    cnt_b <= rd_b ? eff_b + 1 : 0;
    p1v   <= rd_b & ~wr_b;
    p1a   <= addr_b;
    p2v   <= p1v;
    p2a   <= p1a;
  end

  de1_soc_sysid_checker #(
    .READ_LATENCY(0),
    .TIMEOUT_CYCLES(8)
`ifdef SYSID_CHECK_PERIODIC_EN
    ,
    .RECHECK_PERIOD(100)
`endif
  ) dut_a (
    .clock(clock),
    .reset_n(reset_n),
    .start(start_a),
    .busy(busy_a),
    .done(done_a),
    .id_ok(id_ok_a),
    .ts_ok(ts_ok_a),
    .pass(pass_a),
    .timeout_err(tmo_a),
    .id_value(idv_a),
    .ts_value(tsv_a),
    .avm_address(addr_a),
    .avm_read(rd_a),
    .avm_waitrequest(wr_a),
    .avm_readdata(rdata_a)
  );

  de1_soc_sysid_checker #(
    .READ_LATENCY(2)
`ifdef SYSID_CHECK_PERIODIC_EN
    ,
    .RECHECK_PERIOD(100)
`endif
  ) dut_b (
    .clock(clock),
    .reset_n(reset_n),
    .start(start_b),
    .busy(busy_b),
    .done(done_b),
    .id_ok(id_ok_b),
    .ts_ok(ts_ok_b),
    .pass(pass_b),
    .timeout_err(tmo_b),
    .id_value(idv_b),
    .ts_value(tsv_b),
    .avm_address(addr_b),
    .avm_read(rd_b),
    .avm_waitrequest(wr_b),
    .avm_readdata(rdata_b)
  );

  task automatic kick_a(output int lat);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    lat = 1;
    while (!done_a && lat < 60) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic kick_b(output int lat);
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    lat = 1;
    while (!done_b && lat < 60) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] ctl;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    ctl = {busy_a, done_a, id_ok_a, ts_ok_a, pass_a, tmo_a, rd_a, addr_a};
    n_cmp++;
    if (ctl !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_ctl_a: got %b want 00000000", ctl);
    end
    n_cmp++;
    if ({idv_a, tsv_a} !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_val_a: got %h %h want 0 0", idv_a, tsv_a);
    end
    ctl = {busy_b, done_b, id_ok_b, ts_ok_b, pass_b, tmo_b, rd_b, addr_b};
    n_cmp++;
    if (ctl !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_ctl_b: got %b want 00000000", ctl);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

`ifdef SYSID_CHECK_PERIODIC_EN
  task automatic test_periodic();
    int n;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (done_a) break;
    end
    n_cmp++;
    if (n !== 5) begin
      n_bad++;
      $display("FAIL periodic_first: done after %0d want 5", n);
    end
    n_cmp++;
    if (pass_a !== 1'b1) begin
      n_bad++;
      $display("FAIL periodic_pass1: got %b want 1", pass_a);
    end
    n = 0;
    while (n < 150) begin
      @(negedge clock);
      n++;
      if (done_a) break;
    end
    n_cmp++;
    if (n !== 100) begin
      n_bad++;
      $display("FAIL periodic_period: done after %0d want 100", n);
    end
    n_cmp++;
    if (pass_a !== 1'b1) begin
      n_bad++;
      $display("FAIL periodic_pass2: got %b want 1", pass_a);
    end
  endtask
`endif

  task automatic test_zero_wait();
    int lat;
    idw_a = 32'd0;
    tsw_a = EXP_TS;
    kick_a(lat);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL zw_latency: got %0d want 4", lat);
    end
    n_cmp++;
    if ({pass_a, id_ok_a, ts_ok_a, tmo_a, busy_a} !== 5'b11100) begin
      n_bad++;
      $display("FAIL zw_flags: got %b want 11100",
               {pass_a, id_ok_a, ts_ok_a, tmo_a, busy_a});
    end
    n_cmp++;
    if (tsv_a !== EXP_TS || idv_a !== 32'd0) begin
      n_bad++;
      $display("FAIL zw_values: got %h %h want 0 %h", idv_a, tsv_a, EXP_TS);
    end
    @(negedge clock);
    n_cmp++;
    if (done_a !== 1'b0) begin
      n_bad++;
      $display("FAIL zw_done_pulse: got %b want 0", done_a);
    end
  endtask

  task automatic test_id_mismatch();
    int lat;
    idw_a = 32'h1;
    kick_a(lat);
    n_cmp++;
    if ({id_ok_a, ts_ok_a, pass_a} !== 3'b010) begin
      n_bad++;
      $display("FAIL idmis_flags: got %b want 010", {id_ok_a, ts_ok_a, pass_a});
    end
    n_cmp++;
    if (idv_a !== 32'h1) begin
      n_bad++;
      $display("FAIL idmis_value: got %h want 1", idv_a);
    end
    idw_a = 32'd0;
  endtask

  task automatic test_timeout();
    int lat;
    stuck_a = 1'b1;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    lat = 1;
    n_cmp++;
    if ({rd_a, addr_a} !== 2'b10) begin
      n_bad++;
      $display("FAIL to_read_id: got %b want 10", {rd_a, addr_a});
    end
    while (!done_a && lat < 60) begin
      @(negedge clock);
      lat++;
    end
    stuck_a = 1'b0;
    n_cmp++;
    if (lat !== 10) begin
      n_bad++;
      $display("FAIL to_latency: got %0d want 10", lat);
    end
    n_cmp++;
    if ({tmo_a, pass_a, rd_a, busy_a, id_ok_a} !== 5'b10000) begin
      n_bad++;
      $display("FAIL to_flags: got %b want 10000",
               {tmo_a, pass_a, rd_a, busy_a, id_ok_a});
    end
    kick_a(lat);
    n_cmp++;
    if ({lat == 4, pass_a, tmo_a} !== 3'b110) begin
      n_bad++;
      $display("FAIL to_recover: lat %0d pass %b tmo %b want 4 1 0",
               lat, pass_a, tmo_a);
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    int lat;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    @(negedge clock);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    dones = 0;
    repeat (12) begin
      if (done_a) dones++;
      @(negedge clock);
    end
    n_cmp++;
    if (dones !== 1) begin
      n_bad++;
      $display("FAIL b2b_ignore: got %0d dones want 1", dones);
    end
    kick_a(lat);
    kick_a(lat);
    n_cmp++;
    if (lat !== 4 || pass_a !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_restart: lat %0d pass %b want 4 1", lat, pass_a);
    end
  endtask

  task automatic test_latency2();
    int lat;
    kick_b(lat);
    n_cmp++;
    if (lat !== 8) begin
      n_bad++;
      $display("FAIL l2_latency: got %0d want 8", lat);
    end
    n_cmp++;
    if (pass_b !== 1'b1 || idv_b !== 32'd0 || tsv_b !== EXP_TS) begin
      n_bad++;
      $display("FAIL l2_result: pass %b id %h ts %h want 1 0 %h",
               pass_b, idv_b, tsv_b, EXP_TS);
    end
  endtask

  task automatic test_stall_ts();
    int lat;
    int ts_rd;
    int first;
    int last;
    stall_b = 10;
    ts_rd = 0;
    first = -1;
    last = -1;
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    lat = 1;
    while (!done_b && lat < 60) begin
      if (rd_b && addr_b) begin
        ts_rd++;
        if (first < 0) first = lat;
        last = lat;
      end
      @(negedge clock);
      lat++;
    end
    stall_b = 0;
    n_cmp++;
    if (lat !== 18) begin
      n_bad++;
      $display("FAIL stall_latency: got %0d want 18", lat);
    end
    n_cmp++;
    if (ts_rd !== 11 || last - first + 1 !== 11) begin
      n_bad++;
      $display("FAIL stall_stable: reads %0d span %0d want 11 11",
               ts_rd, last - first + 1);
    end
    n_cmp++;
    if (pass_b !== 1'b1 || tsv_b !== EXP_TS) begin
      n_bad++;
      $display("FAIL stall_result: pass %b ts %h want 1 %h", pass_b, tsv_b, EXP_TS);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    logic [7:0] ctl;
    start_b = 1'b1;
    @(negedge clock);
    start_b = 1'b0;
    repeat (4) @(negedge clock);
    n_cmp++;
    if ({busy_b, id_ok_b, rd_b} !== 3'b110) begin
      n_bad++;
      $display("FAIL abort_pre: got %b want 110", {busy_b, id_ok_b, rd_b});
    end
    reset_n = 1'b0;
    @(negedge clock);
    ctl = {busy_b, done_b, id_ok_b, ts_ok_b, pass_b, tmo_b, rd_b, addr_b};
    n_cmp++;
    if (ctl !== 8'h00 || {idv_b, tsv_b} !== 64'd0) begin
      n_bad++;
      $display("FAIL abort_clear: ctl %b id %h ts %h want 0", ctl, idv_b, tsv_b);
    end
    reset_n = 1'b1;
    dones = 0;
    repeat (10) begin
      @(negedge clock);
      if (done_b) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++;
      $display("FAIL abort_nodone: got %0d dones want 0", dones);
    end
  endtask

  initial begin
    test_reset();
`ifdef SYSID_CHECK_PERIODIC_EN
    test_periodic();
`else
    test_zero_wait();
    test_id_mismatch();
    test_timeout();
    test_back_to_back();
    test_latency2();
    test_stall_ts();
    test_reset_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
